dotp_stream_mac: RTL and testbench
==================================

Name: dotp_stream_mac

Overview:
- Sequential, streaming counterpart of the team's wide combinational sum-of-products library cells.
- Accepts operand pairs one per cycle over a valid/ready handshake and accumulates their products modulo 2^WIDTH.
- Emits one result per packet, where a packet is a sequence of beats terminated by in_last.
- Used as the multi-cycle reference engine that feeds and cross-checks the single-cycle arithmetic cells in the synthesis test flow.

Parameters:
- WIDTH, 18, operand/product/accumulator width; all arithmetic is modulo 2^WIDTH.
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  engine can accept a beat.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_last  input  1  beat is the final term of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum of products, mod 2^WIDTH.
- out_terms  output  CNT_W  number of beats in packet, saturating.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: in_ready=0 during rst, 1 on the first cycle after release. out_valid=0, out_sum=0, out_terms=0. Internal accumulator, counter, stage-1 registers and state are all cleared.
- States: ACCUM, DRAIN, HOLD.
  - ACCUM: in_ready=1.
  - DRAIN, HOLD: in_ready=0.
- Beat acceptance: a beat is taken on any edge with in_valid && in_ready.
- Pipeline stage 1: registers p = (in_a*in_b)[WIDTH-1:0] plus a valid bit and a last bit.
- Pipeline stage 2: on a stage-1 valid, acc <= acc + p (mod 2^WIDTH). The counter increments and saturates at 2^CNT_W-1.
- Transitions:
  - ACCUM -> DRAIN on acceptance of a beat with in_last=1.
  - DRAIN -> HOLD when the last product is added.
  - In the same edge as DRAIN -> HOLD: out_sum <= final acc, out_terms <= final count, out_valid <= 1.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+2.
- Throughput: one beat per cycle inside a packet. A new packet's first beat is accepted the cycle after the result handshake.
- HOLD:
  - out_valid stays 1; out_sum and out_terms stay stable until out_valid && out_ready.
  - On the handshake edge: out_valid <= 0, acc and count cleared, state -> ACCUM.
- out_ready is ignored while out_valid=0.
- in_valid with in_ready=0 is ignored: no state change, no data capture.
- Single-beat packet (in_last on the first beat) gives out_terms=1.
- Products overflowing WIDTH are truncated before accumulation. The accumulator wraps silently; no overflow flag.
- Asserting rst mid-packet or in HOLD immediately drops out_valid and discards all partial state.

Optional Feature:
- Macro: DOTP_REDUCE_FLAGS_EN.
- With the macro defined, three extra outputs are added: red_and, red_or, red_xor, 1 bit each.
  - Each equals &, |, ^ of the value registered into out_sum.
  - They are registered on the same edge and held with out_sum.
  - Reset value 0.
- Without the macro, these ports and their logic do not exist.
- Core behaviour is identical either way.

Test Plan:
- Three-beat packet: beats (3,4), (5,6), (7,8 last), out_ready=1 -> out_valid 2 cycles after the last beat, out_sum=98, out_terms=3, in_ready back to 1 the cycle after the handshake.
- Wrap: beats (0x3FFFF,0x3FFFF), then (0x20000,2 last) -> product terms 1 and 0, out_sum=1, out_terms=2.
- Backpressure: after the result, hold out_ready=0 for 5 cycles while in_valid=1 with new data -> out_sum and out_terms stable, in_ready=0, no beat consumed; release out_ready -> next packet starts fresh from acc=0.
- Single-beat packet (9,9 last) -> out_sum=81, out_terms=1. A back-to-back second packet (1,1 last) -> out_sum=1, with no carry-over of the accumulator.
- Reset mid-operation: assert rst asynchronously between clock edges after 2 beats of a 3-beat packet -> out_valid, out_sum and out_terms read 0 immediately. After release, a new packet (2,3 last) -> out_sum=6, out_terms=1.
- With DOTP_REDUCE_FLAGS_EN: packet (0x3FFFF,1 last) -> out_sum=0x3FFFF, red_and=1, red_or=1, red_xor=0. Packet (0,5 last) -> out_sum=0, red_and=0, red_or=0, red_xor=0.

Source files
------------

// File: rtl/dotp_stream_mac_if.sv
// Operand/result handshake bundle for dotp_stream_mac.
// master = beat producer / result consumer, slave = the MAC engine.
// Optional reduction-flag wires exist only when DOTP_REDUCE_FLAGS_EN is defined.
interface dotp_stream_mac_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_terms;

`ifdef DOTP_REDUCE_FLAGS_EN
  logic             red_and;
  logic             red_or;
  logic             red_xor;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_terms, red_and, red_or, red_xor
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_terms, red_and, red_or, red_xor
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_terms
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_terms
  );
`endif
endinterface

// File: rtl/dotp_stream_mac.sv
// Streaming sum-of-products: accumulates (a*b mod 2^WIDTH) per packet, one result per in_last.
// Latency: last beat accepted at edge t -> out_valid high after edge t+2; one beat/cycle in a packet.
// Backpressure: result held in HOLD until out_ready; input stalled (in_ready=0) from last beat to handshake.
// Optional macro DOTP_REDUCE_FLAGS_EN adds registered &,|,^ flags of out_sum.
module dotp_stream_mac #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dotp_stream_mac_if.slave       bus
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;

  // Gates in_ready so it stays low while reset is held and rises only after
  // the first clock edge following release.
  logic             live_q, live_d;

  // Stage 1: truncated product of the accepted beat.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_last_q, s1_last_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;

  // Stage 2 bookkeeping: set on the edge the last product lands in acc.
  logic             s2_done_q, s2_done_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_terms_q, out_terms_d;

`ifdef DOTP_REDUCE_FLAGS_EN
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
`endif

  logic             in_rdy;
  logic             accept;
  logic             out_hs;
  logic [WIDTH-1:0] prod;

  assign in_rdy = live_q && (state_q == ACCUM);
  assign accept = bus.in_valid && in_rdy;
  // out_ready only matters while a result is actually presented.
  assign out_hs = out_valid_q && bus.out_ready;

  // Multiply in WIDTH-bit context: only the low WIDTH bits are ever needed,
  // so overflow bits of the full product are dropped here.
  assign prod = bus.in_a * bus.in_b;

  // FSM next-state: packet collection, pipeline drain, result hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: begin
        if (accept && bus.in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (s2_done_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_hs) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Datapath next-state: product stage, accumulator/counter, result capture.
  always_comb begin
    live_d      = 1'b1;

    s1_vld_d    = accept;
    s1_last_d   = accept && bus.in_last;
    s1_p_d      = s1_p_q;
    if (accept) begin
      s1_p_d = prod;
    end

    s2_done_d   = s1_vld_q && s1_last_q;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (out_hs) begin
      // Result consumed: the next packet starts from a clean accumulator.
      acc_d = '0;
      cnt_d = '0;
    end else if (s1_vld_q) begin
      acc_d = acc_q + s1_p_q;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_terms_d = out_terms_q;
    if (s2_done_q) begin
      // acc_q/cnt_q already include the last term at this point.
      out_valid_d = 1'b1;
      out_sum_d   = acc_q;
      out_terms_d = cnt_q;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

`ifdef DOTP_REDUCE_FLAGS_EN
    red_and_d = red_and_q;
    red_or_d  = red_or_q;
    red_xor_d = red_xor_q;
    if (s2_done_q) begin
      red_and_d = &acc_q;
      red_or_d  = |acc_q;
      red_xor_d = ^acc_q;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any partial packet and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_p_q      <= '0;
      s2_done_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_terms_q <= '0;
    end else begin
      live_q      <= live_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_p_q      <= s1_p_d;
      s2_done_q   <= s2_done_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_terms_q <= out_terms_d;
    end
  end

`ifdef DOTP_REDUCE_FLAGS_EN
  // Reduction flags, captured alongside out_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_and_q <= 1'b0;
      red_or_q  <= 1'b0;
      red_xor_q <= 1'b0;
    end else begin
      red_and_q <= red_and_d;
      red_or_q  <= red_or_d;
      red_xor_q <= red_xor_d;
    end
  end

  assign bus.red_and = red_and_q;
  assign bus.red_or  = red_or_q;
  assign bus.red_xor = red_xor_q;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_terms = out_terms_q;

endmodule

// File: tb/tb_dotp_stream_mac.sv
// Directed bench for dotp_stream_mac: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every result handshake.
// Reduction flags are checked too when DOTP_REDUCE_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_dotp_stream_mac;
  localparam int WIDTH = 18;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dotp_stream_mac_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  dotp_stream_mac #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] terms;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] sum, input logic [CNT_W-1:0] terms);
    exp_t e;
    e.sum   = sum;
    e.terms = terms;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a result is consumed on the edge after a negedge
  // where out_valid && out_ready, so each result is seen exactly once here.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got sum 0x%0h terms %0d, want no result",
                 bus.out_sum, bus.out_terms);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_sum", 32'(bus.out_sum), 32'(mon_e.sum));
        check("out_terms", 32'(bus.out_terms), 32'(mon_e.terms));
`ifdef DOTP_REDUCE_FLAGS_EN
        check("red_and", 32'(bus.red_and), 32'(&mon_e.sum));
        check("red_or", 32'(bus.red_or), 32'(|mon_e.sum));
        check("red_xor", 32'(bus.red_xor), 32'(^mon_e.sum));
`endif
      end
    end
  end

  // Drive one beat and hold it until accepted; returns 1ns after the accept edge.
  task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic last);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_accept_timeout: in_ready 0, want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) until out_valid is seen at a negedge.
  task automatic wait_out_valid();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL out_valid_timeout: out_valid 0, want 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_terms", 32'(bus.out_terms), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Three-beat packet with latency and ready-return checks: 12+30+56 = 98.
    push_exp(18'd98, 8'd3);
    send_beat(18'd3, 18'd4, 1'b0);
    send_beat(18'd5, 18'd6, 1'b0);
    send_beat(18'd7, 18'd8, 1'b1);
    @(negedge clk);
    check("lat_edge_t", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_t1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_t2", 32'(bus.out_valid), 32'd1);
    check("drain_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("rdy_after_hs", 32'(bus.in_ready), 32'd1);
    check("valid_after_hs", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Wrap packet under backpressure: 0x3FFFF^2 mod 2^18 = 1, 0x20000*2 mod 2^18 = 0.
    bus.out_ready = 1'b0;
    push_exp(18'd1, 8'd2);
    send_beat(18'h3FFFF, 18'h3FFFF, 1'b0);
    send_beat(18'h20000, 18'd2, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 18'd5;
    bus.in_b     = 18'd5;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_sum", 32'(bus.out_sum), 32'd1);
      check("hold_out_terms", 32'(bus.out_terms), 32'd2);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Single-beat packet, then back-to-back single beat with no carry-over.
    push_exp(18'd81, 8'd1);
    send_beat(18'd9, 18'd9, 1'b1);
    push_exp(18'd1, 8'd1);
    send_beat(18'd1, 18'd1, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;

    // Asynchronous reset two beats into a three-beat packet; out_sum held 1 before.
    send_beat(18'd1, 18'd2, 1'b0);
    send_beat(18'd3, 18'd4, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("mid_rst_out_terms", 32'(bus.out_terms), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp(18'd6, 8'd1);
    send_beat(18'd2, 18'd3, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;

    // Reduction-flag vectors (sum checked in every build).
    push_exp(18'h3FFFF, 8'd1);
    send_beat(18'h3FFFF, 18'd1, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;
    push_exp(18'd0, 8'd1);
    send_beat(18'd0, 18'd5, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;

    // Counter saturation: 300 beats of 1*1 -> sum 300, terms clipped at 255.
    push_exp(18'd300, 8'd255);
    for (int i = 0; i < 300; i++) begin
      send_beat(18'd1, 18'd1, (i == 299) ? 1'b1 : 1'b0);
    end
    wait_out_valid();
    @(posedge clk);
    #1;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
